// File: rtl/msg_scheduler.sv
// Round-robin message scheduler: copies null-terminated strings from a
// synchronous memory into the UART transmit FIFO, one whole message at a time.
module msg_scheduler #(
  parameter int                ADDR_W = 4,
  parameter logic [ADDR_W-1:0] BASE_A = 4'd0,
  parameter logic [ADDR_W-1:0] BASE_B = 4'd8,
  parameter int                MAXLEN = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        req_i,
  output logic              busy_o,
  output logic [1:0]        grant_o,
  output logic              done_o,
  output logic              trunc_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_data_i,
  output logic [7:0]        fifo_byte_o,
  output logic              fifo_wren_o,
  input  logic              fifo_full_i
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    CHK
  } state_t;

  localparam logic [7:0] MAXLEN_C = 8'(MAXLEN);

  state_t      state;
  logic [1:0]  pending;
  logic        last_b;
  logic [7:0]  count;
  logic        pick_b;
  logic [1:0]  grant_vec;
  logic [7:0]  count_inc;

  // B wins when it is the only one pending, or on a tie when A was served last.
  always_comb begin
    pick_b    = (pending == 2'b10) || ((pending == 2'b11) && !last_b);
    grant_vec = pick_b ? 2'b10 : 2'b01;
    count_inc = count + 8'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      pending     <= 2'b00;
      last_b      <= 1'b1;
      count       <= 8'd0;
      busy_o      <= 1'b0;
      grant_o     <= 2'b00;
      done_o      <= 1'b0;
      trunc_o     <= 1'b0;
      mem_addr_o  <= '0;
      fifo_byte_o <= 8'd0;
      fifo_wren_o <= 1'b0;
    end else begin
      done_o      <= 1'b0;
      trunc_o     <= 1'b0;
      fifo_wren_o <= 1'b0;
      pending     <= pending | req_i;

      case (state)
        IDLE: begin
          if (pending != 2'b00) begin
            // A request arriving on the grant edge re-arms the winner's bit.
            pending    <= (pending & ~grant_vec) | req_i;
            grant_o    <= grant_vec;
            busy_o     <= 1'b1;
            mem_addr_o <= pick_b ? BASE_B : BASE_A;
            count      <= 8'd0;
            last_b     <= pick_b;
            state      <= RD;
          end
        end

        RD: begin
          state <= CHK;
        end

        CHK: begin
          if (mem_data_i == 8'd0) begin
            done_o  <= 1'b1;
            grant_o <= 2'b00;
            busy_o  <= 1'b0;
            state   <= IDLE;
          end else if (!fifo_full_i) begin
            fifo_byte_o <= mem_data_i;
            fifo_wren_o <= 1'b1;
            count       <= count_inc;
            mem_addr_o  <= mem_addr_o + ADDR_W'(1);
            if (count_inc == MAXLEN_C) begin
              trunc_o <= 1'b1;
              grant_o <= 2'b00;
              busy_o  <= 1'b0;
              state   <= IDLE;
            end else begin
              state <= RD;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_scheduler.sv
// Randomized bench for msg_scheduler: a queue-based model of the message rules
// predicts bytes, owners, grant order and timing; a second instance covers truncation.
module tb_msg_scheduler;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [1:0] req_i = 2'b00;
  logic       fifo_full_i = 1'b0;
  logic [7:0] mem_data_i;
  logic       busy_o, done_o, trunc_o, fifo_wren_o;
  logic [1:0] grant_o;
  logic [3:0] mem_addr_o;
  logic [7:0] fifo_byte_o;

  logic [1:0] req2 = 2'b00;
  logic [7:0] mem_data2;
  logic       busy2, done2, trunc2, wren2;
  logic [1:0] grant2;
  logic [3:0] addr2;
  logic [7:0] byte2;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  msg_scheduler dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .busy_o(busy_o), .grant_o(grant_o),
    .done_o(done_o), .trunc_o(trunc_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .fifo_byte_o(fifo_byte_o), .fifo_wren_o(fifo_wren_o), .fifo_full_i(fifo_full_i)
  );

  msg_scheduler #(.ADDR_W(4), .BASE_A(4'd0), .BASE_B(4'd14), .MAXLEN(3)) dut_t (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req2), .busy_o(busy2), .grant_o(grant2),
    .done_o(done2), .trunc_o(trunc2), .mem_addr_o(addr2), .mem_data_i(mem_data2),
    .fifo_byte_o(byte2), .fifo_wren_o(wren2), .fifo_full_i(1'b0)
  );

  logic [7:0] mem [16];
  logic [7:0] mem2 [16];

  always @(posedge clk_i) mem_data_i <= mem[mem_addr_o];
  always @(posedge clk_i) mem_data2  <= mem2[addr2];

  int   cyc = 0;
  logic full_s = 1'b0;

  always @(posedge clk_i) begin
    cyc    <= cyc + 1;
    full_s <= fifo_full_i;
  end

  logic [7:0] wr_byte[$];
  int         wr_cyc[$];
  logic [1:0] wr_own[$];
  int         ev_kind[$];
  int         ev_cyc[$];
  logic [1:0] gnt_val[$];
  int         gnt_cyc[$];
  logic [1:0] cur_owner = 2'b00;
  logic [1:0] prev_gnt = 2'b00;
  int         viol = 0;

  // Observation log for the main instance, sampled on the falling edge.
  always @(negedge clk_i) begin
    if (grant_o != 2'b00) begin
      if (grant_o != prev_gnt) begin
        gnt_val.push_back(grant_o);
        gnt_cyc.push_back(cyc);
      end
      cur_owner = grant_o;
    end
    prev_gnt = grant_o;
    if (fifo_wren_o) begin
      wr_byte.push_back(fifo_byte_o);
      wr_cyc.push_back(cyc);
      wr_own.push_back(cur_owner);
      if (full_s) viol++;
    end
    if (done_o)  begin ev_kind.push_back(0); ev_cyc.push_back(cyc); end
    if (trunc_o) begin ev_kind.push_back(1); ev_cyc.push_back(cyc); end
  end

  logic [7:0] t2_byte[$];
  int         t2_cyc[$];
  int         t2_done = 0;
  int         t2_trunc = 0;
  int         t2_trunc_cyc = -1;

  always @(negedge clk_i) begin
    if (wren2) begin t2_byte.push_back(byte2); t2_cyc.push_back(cyc); end
    if (done2) t2_done++;
    if (trunc2) begin t2_trunc++; t2_trunc_cyc = cyc; end
  end

  // Reference model: expected bytes/owners/events derived from memory contents.
  logic [7:0] exp_byte[$];
  logic [1:0] exp_own[$];
  int         exp_ev[$];
  logic [1:0] exp_gnt[$];
  bit         last_b_m = 1'b1;

  task automatic model_msg(input logic [1:0] owner);
    int base = (owner == 2'b01) ? 0 : 8;
    bit term = 1'b0;
    int k = 0;
    exp_gnt.push_back(owner);
    while (!term && k < 15) begin
      if (mem[(base + k) % 16] == 8'h00) term = 1'b1;
      else begin
        exp_byte.push_back(mem[(base + k) % 16]);
        exp_own.push_back(owner);
        k++;
      end
    end
    exp_ev.push_back(term ? 0 : 1);
  endtask

  task automatic model_serve(input logic [1:0] r);
    if (r == 2'b11) begin
      if (last_b_m) begin model_msg(2'b01); model_msg(2'b10); last_b_m = 1'b1; end
      else          begin model_msg(2'b10); model_msg(2'b01); last_b_m = 1'b0; end
    end else if (r == 2'b01) begin
      model_msg(2'b01); last_b_m = 1'b0;
    end else if (r == 2'b10) begin
      model_msg(2'b10); last_b_m = 1'b1;
    end
  endtask

  task automatic clear_logs();
    wr_byte.delete(); wr_cyc.delete(); wr_own.delete();
    ev_kind.delete(); ev_cyc.delete(); gnt_val.delete(); gnt_cyc.delete();
    exp_byte.delete(); exp_own.delete(); exp_ev.delete(); exp_gnt.delete();
  endtask

  task automatic fill_string(input int base, input int len);
    for (int k = 0; k < len; k++) mem[(base + k) % 16] = 8'($urandom_range(1, 255));
    mem[(base + len) % 16] = 8'h00;
  endtask

  task automatic pulse_req(input logic [1:0] r, output int e);
    @(negedge clk_i); #1;
    req_i = r;
    e = cyc + 1;
    @(negedge clk_i); #1;
    req_i = 2'b00;
  endtask

  task automatic wait_events(input int n, input int budget, output bit ok);
    int k = 0;
    while (ev_kind.size() < n && k < budget) begin
      @(negedge clk_i); #1;
      k++;
    end
    ok = (ev_kind.size() >= n);
    repeat (4) begin @(negedge clk_i); #1; end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    checks++;
    if ({busy_o, grant_o, done_o, trunc_o, fifo_wren_o, fifo_byte_o, mem_addr_o} !== 18'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %05h expected 00000",
               {busy_o, grant_o, done_o, trunc_o, fifo_wren_o, fifo_byte_o, mem_addr_o});
    end
    rst_i = 1'b0;
    last_b_m = 1'b1;
  endtask

  task automatic test_hello();
    int e; bit ok;
    mem[0] = "H"; mem[1] = "E"; mem[2] = "L"; mem[3] = "L"; mem[4] = "O"; mem[5] = 8'h00;
    clear_logs();
    model_serve(2'b01);
    pulse_req(2'b01, e);
    wait_events(1, 60, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL hello_timeout: got %0d events expected 1", ev_kind.size()); end
    checks++;
    if (wr_byte.size() != exp_byte.size()) begin
      errors++; $display("[TB] FAIL hello_count: got %0d expected %0d", wr_byte.size(), exp_byte.size());
    end
    for (int i = 0; i < exp_byte.size(); i++) begin
      checks++;
      if (wr_byte[i] !== exp_byte[i] || wr_cyc[i] != e + 3 + 2 * i) begin
        errors++;
        $display("[TB] FAIL hello_byte[%0d]: got %02h@%0d expected %02h@%0d", i, wr_byte[i], wr_cyc[i],
                 exp_byte[i], e + 3 + 2 * i);
      end
    end
    checks++;
    if (gnt_cyc.size() != 1 || gnt_cyc[0] != e + 1 || gnt_val[0] !== 2'b01) begin
      errors++; $display("[TB] FAIL hello_grant: got %0d grants first at %0d expected 1 at %0d", gnt_cyc.size(), gnt_cyc[0], e + 1);
    end
    checks++;
    if (ev_kind.size() != 1 || ev_kind[0] != 0 || ev_cyc[0] != e + 13) begin
      errors++; $display("[TB] FAIL hello_done: got kind %0d at %0d expected done at %0d", ev_kind[0], ev_cyc[0], e + 13);
    end
    checks++;
    if (grant_o !== 2'b00 || busy_o !== 1'b0) begin
      errors++; $display("[TB] FAIL hello_idle: got grant %0b busy %0b expected 00 0", grant_o, busy_o);
    end
  endtask

  task automatic test_empty();
    int e; bit ok;
    mem[0] = 8'h00;
    clear_logs();
    model_serve(2'b01);
    pulse_req(2'b01, e);
    wait_events(1, 20, ok);
    checks++;
    if (!ok || ev_kind[0] != exp_ev[0] || ev_cyc[0] != e + 3) begin
      errors++; $display("[TB] FAIL empty_done: got %0d events, first at %0d expected done at %0d", ev_kind.size(), ev_cyc[0], e + 3);
    end
    checks++;
    if (wr_byte.size() != 0) begin
      errors++; $display("[TB] FAIL empty_writes: got %0d expected 0", wr_byte.size());
    end
  endtask

  task automatic test_both();
    logic [1:0] pattern [5] = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11};
    int e; bit ok;
    for (int r = 0; r < 5; r++) begin
      fill_string(0, $urandom_range(1, 7));
      fill_string(8, $urandom_range(1, 7));
      clear_logs();
      model_serve(pattern[r]);
      pulse_req(pattern[r], e);
      wait_events(exp_ev.size(), 80, ok);
      checks++;
      if (!ok || wr_byte.size() != exp_byte.size()) begin
        errors++; $display("[TB] FAIL both%0d_count: got %0d bytes expected %0d", r, wr_byte.size(), exp_byte.size());
      end
      for (int i = 0; i < exp_byte.size(); i++) begin
        checks++;
        if (wr_byte[i] !== exp_byte[i] || wr_own[i] !== exp_own[i]) begin
          errors++;
          $display("[TB] FAIL both%0d_byte[%0d]: got %02h/%0b expected %02h/%0b", r, i, wr_byte[i], wr_own[i], exp_byte[i], exp_own[i]);
        end
      end
      for (int i = 0; i < exp_gnt.size(); i++) begin
        checks++;
        if (gnt_val[i] !== exp_gnt[i] || ev_kind[i] != exp_ev[i]) begin
          errors++; $display("[TB] FAIL both%0d_order[%0d]: got grant %0b expected %0b", r, i, gnt_val[i], exp_gnt[i]);
        end
      end
      if (pattern[r] == 2'b11) begin
        checks++;
        if (gnt_cyc[1] != ev_cyc[0] + 1) begin
          errors++; $display("[TB] FAIL both%0d_gap: got second grant at %0d expected %0d", r, gnt_cyc[1], ev_cyc[0] + 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int e; int w; int k; bit ok;
    fill_string(0, 8);
    clear_logs();
    model_serve(2'b01);
    pulse_req(2'b01, e);
    k = 0;
    while (wr_byte.size() < 2 && k < 40) begin @(negedge clk_i); #1; k++; end
    w = wr_cyc[1];
    fifo_full_i = 1'b1;
    repeat (7) begin @(negedge clk_i); #1; end
    fifo_full_i = 1'b0;
    wait_events(1, 60, ok);
    checks++;
    if (!ok || wr_byte.size() != exp_byte.size()) begin
      errors++; $display("[TB] FAIL stall_count: got %0d bytes expected %0d", wr_byte.size(), exp_byte.size());
    end
    checks++;
    if (wr_cyc[2] != w + 8) begin
      errors++; $display("[TB] FAIL stall_resume: got write at %0d expected %0d", wr_cyc[2], w + 8);
    end
    for (int i = 0; i < exp_byte.size(); i++) begin
      checks++;
      if (wr_byte[i] !== exp_byte[i]) begin
        errors++; $display("[TB] FAIL stall_byte[%0d]: got %02h expected %02h", i, wr_byte[i], exp_byte[i]);
      end
    end
    // Second message with random back-pressure on every cycle.
    fill_string(0, $urandom_range(6, 10));
    clear_logs();
    model_serve(2'b01);
    pulse_req(2'b01, e);
    k = 0;
    while (ev_kind.size() < 1 && k < 300) begin
      fifo_full_i = ($urandom_range(0, 9) < 4);
      @(negedge clk_i); #1;
      k++;
    end
    fifo_full_i = 1'b0;
    wait_events(1, 10, ok);
    checks++;
    if (!ok || wr_byte.size() != exp_byte.size()) begin
      errors++; $display("[TB] FAIL rndfull_count: got %0d bytes expected %0d", wr_byte.size(), exp_byte.size());
    end
    for (int i = 0; i < exp_byte.size(); i++) begin
      checks++;
      if (wr_byte[i] !== exp_byte[i]) begin
        errors++; $display("[TB] FAIL rndfull_byte[%0d]: got %02h expected %02h", i, wr_byte[i], exp_byte[i]);
      end
    end
    checks++;
    if (viol != 0) begin
      errors++; $display("[TB] FAIL write_while_full: got %0d expected 0", viol);
    end
  endtask

  task automatic test_truncate();
    int e; int k;
    for (int i = 0; i < 16; i++) mem2[i] = 8'($urandom_range(1, 255));
    t2_byte.delete(); t2_cyc.delete(); t2_done = 0; t2_trunc = 0;
    @(negedge clk_i); #1;
    req2 = 2'b10;
    e = cyc + 1;
    @(negedge clk_i); #1;
    req2 = 2'b00;
    k = 0;
    while (t2_trunc == 0 && k < 30) begin @(negedge clk_i); #1; k++; end
    repeat (6) begin @(negedge clk_i); #1; end
    checks++;
    if (t2_byte.size() != 3) begin
      errors++; $display("[TB] FAIL trunc_count: got %0d expected 3", t2_byte.size());
    end
    checks++;
    if (t2_byte[0] !== mem2[14] || t2_byte[1] !== mem2[15] || t2_byte[2] !== mem2[0]) begin
      errors++; $display("[TB] FAIL trunc_bytes: got %02h %02h %02h expected %02h %02h %02h",
                         t2_byte[0], t2_byte[1], t2_byte[2], mem2[14], mem2[15], mem2[0]);
    end
    checks++;
    if (t2_trunc != 1 || t2_trunc_cyc != e + 7 || t2_cyc[2] != e + 7) begin
      errors++; $display("[TB] FAIL trunc_pulse: got %0d pulses at %0d expected 1 at %0d", t2_trunc, t2_trunc_cyc, e + 7);
    end
    checks++;
    if (t2_done != 0 || grant2 !== 2'b00 || busy2 !== 1'b0) begin
      errors++; $display("[TB] FAIL trunc_idle: got done %0d grant %0b expected 0 00", t2_done, grant2);
    end
  endtask

  task automatic test_reset_mid();
    int e; int k; int nwr; bit ok;
    fill_string(0, 11);
    clear_logs();
    pulse_req(2'b01, e);
    k = 0;
    while (wr_byte.size() < 2 && k < 40) begin @(negedge clk_i); #1; k++; end
    req_i = 2'b10;
    @(negedge clk_i); #1;
    req_i = 2'b00;
    #1;
    rst_i = 1'b1;
    #1;
    checks++;
    if ({busy_o, grant_o, done_o, trunc_o, fifo_wren_o, fifo_byte_o, mem_addr_o} !== 18'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got %05h expected 00000",
               {busy_o, grant_o, done_o, trunc_o, fifo_wren_o, fifo_byte_o, mem_addr_o});
    end
    nwr = wr_byte.size();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    last_b_m = 1'b1;
    repeat (12) begin @(negedge clk_i); #1; end
    checks++;
    if (wr_byte.size() != nwr || busy_o !== 1'b0 || ev_kind.size() != 0) begin
      errors++; $display("[TB] FAIL reset_abort: got %0d writes busy %0b expected %0d writes busy 0", wr_byte.size(), busy_o, nwr);
    end
    clear_logs();
    model_serve(2'b01);
    pulse_req(2'b01, e);
    wait_events(1, 80, ok);
    checks++;
    if (!ok || wr_byte.size() != 11 || ev_kind[0] != 0) begin
      errors++; $display("[TB] FAIL restart_count: got %0d bytes expected 11", wr_byte.size());
    end
    for (int i = 0; i < exp_byte.size(); i++) begin
      checks++;
      if (wr_byte[i] !== exp_byte[i]) begin
        errors++; $display("[TB] FAIL restart_byte[%0d]: got %02h expected %02h", i, wr_byte[i], exp_byte[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin mem[i] = 8'h00; mem2[i] = 8'h01; end
    test_reset();
    test_hello();
    test_empty();
    test_both();
    test_backpressure();
    test_truncate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
